// File: rtl/rcs_seq_addsub.sv
// Multi-cycle ripple-carry adder/subtractor.
// Operands are accepted over a valid/ready handshake, summed CHUNK bits per
// clock (LSB chunk first) through a registered carry, and the result is held
// under valid/ready backpressure until the consumer takes it.
module rcs_seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             cy_q, cy_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] b_eff_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] r_upd;
    logic             last_chunk;
    logic             b_eff_msb;

    // Chunk datapath: select chunk k, add with registered carry, merge into shadow.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        b_eff_chunk = sub_q ? ~b_chunk : b_chunk;
        chunk_sum   = {1'b0, a_chunk} + {1'b0, b_eff_chunk} + {{CHUNK{1'b0}}, cy_q};
        r_upd = r_q;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                r_upd[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
        last_chunk = (k_q == KW'(NCHUNK - 1));
        b_eff_msb  = sub_q ^ b_q[WIDTH-1];
    end

    // Next-state and register-update logic for IDLE/CALC/DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        cy_d     = cy_q;
        k_d      = k_q;
        r_d      = r_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    cy_d    = sub;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d  = r_upd;
                cy_d = chunk_sum[CHUNK];
                k_d  = k_q + 1'b1;
                if (last_chunk) begin
                    k_d      = '0;
                    result_d = r_upd;
                    carry_d  = sub_q ? ~chunk_sum[CHUNK] : chunk_sum[CHUNK];
                    ovf_d    = (a_q[WIDTH-1] == b_eff_msb) && (r_upd[WIDTH-1] != a_q[WIDTH-1]);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            cy_q     <= 1'b0;
            k_q      <= '0;
            r_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            cy_q     <= cy_d;
            k_q      <= k_d;
            r_q      <= r_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule
